// File: rtl/alu_pkg.sv
// Shared encodings for the alu_pipe datapath: op codes, flag bit positions
// and multiplier FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_NEG = 4'd2;
  localparam logic [3:0] ALU_OP_AND = 4'd3;
  localparam logic [3:0] ALU_OP_ORR = 4'd4;
  localparam logic [3:0] ALU_OP_EOR = 4'd5;
  localparam logic [3:0] ALU_OP_LSL = 4'd6;
  localparam logic [3:0] ALU_OP_LSR = 4'd7;
  localparam logic [3:0] ALU_OP_ADC = 4'd8;
  localparam logic [3:0] ALU_OP_SBC = 4'd9;
  localparam logic [3:0] ALU_OP_ASR = 4'd10;
  localparam logic [3:0] ALU_OP_ROR = 4'd11;
  localparam logic [3:0] ALU_OP_MUL = 4'd12;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH
// cycles, then holds the product in DONE until the consumer acknowledges.
//
// state    | meaning
// MUL_IDLE | waiting for i_start
// MUL_BUSY | accumulating one multiplier bit per cycle
// MUL_DONE | o_prod valid, waiting for i_ack
module alu_mul_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_ack,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t         r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MUL_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: if (i_start) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, i_a};
          r_mplier <= i_b;
          r_cnt    <= CW'(WIDTH - 1);
          r_state  <= MUL_BUSY;
        end
        MUL_BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == '0) r_state <= MUL_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        MUL_DONE: if (i_ack) r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != MUL_IDLE);
  assign o_done = (r_state == MUL_DONE);
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// WIDTH-parametrised ALU with NZCV flags, carry chaining and one registered
// output stage with valid/ready on both sides. ALU_MUL_EN adds op 12 MUL.
module alu_pipe import alu_pkg::*; #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam logic [SHW:0] LP_W = (SHW + 1)'(WIDTH);

  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;
  logic             r_out_valid;
  logic             r_cr;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_add_v;
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [SHW:0]     w_shext;
  logic [SHW:0]     w_ramt;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_busy;
  logic             w_single;
  logic             w_out_free;
  logic             w_accept;

  always_comb begin
    w_b_eff = b;
    w_cin   = 1'b0;
    case (op)
      ALU_OP_SUB: begin w_b_eff = ~b; w_cin = 1'b1; end
      ALU_OP_ADC: w_cin = r_cr;
      ALU_OP_SBC: begin w_b_eff = ~b; w_cin = r_cr; end
      default: ;
    endcase
  end

  // Subtraction is a + ~b + cin, so the carry out is directly !borrow.
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  assign w_add_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  assign w_lsl   = {1'b0, a} << shamt;
  assign w_lsr   = {a, 1'b0} >> shamt;
  assign w_asr   = $signed({a, 1'b0}) >>> shamt;
  assign w_shext = {1'b0, shamt};
  assign w_ramt  = (w_shext >= LP_W) ? (w_shext - LP_W) : w_shext;
  assign w_ror   = (a >> w_ramt) | (a << (LP_W - w_ramt));

  always_comb begin
    w_res = a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_ADC, ALU_OP_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      ALU_OP_NEG: w_res = ~b;
      ALU_OP_AND: w_res = a & b;
      ALU_OP_ORR: w_res = a | b;
      ALU_OP_EOR: w_res = a ^ b;
      ALU_OP_LSL: {w_c, w_res} = w_lsl;
      ALU_OP_LSR: {w_res, w_c} = w_lsr;
      ALU_OP_ASR: {w_res, w_c} = w_asr;
      ALU_OP_ROR: begin
        w_res = w_ror;
        w_c   = (shamt != '0) && w_ror[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = !w_busy && w_out_free;
  assign w_accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  logic               w_mul_done;
  logic               w_mul_ack;
  logic [2*WIDTH-1:0] w_prod;

  assign w_single  = (op != ALU_OP_MUL);
  assign w_mul_ack = w_mul_done && w_out_free;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && !w_single),
    .i_a     (a),
    .i_b     (b),
    .i_ack   (w_mul_ack),
    .o_busy  (w_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );
`else
  assign w_single = 1'b1;
  assign w_busy   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_cr        <= 1'b0;
    end else if (w_accept && w_single) begin
      r_out           <= w_res;
      r_flags[FLAG_N] <= w_res[WIDTH-1];
      r_flags[FLAG_Z] <= (w_res == '0);
      r_flags[FLAG_C] <= w_c;
      r_flags[FLAG_V] <= w_v;
      r_out_valid     <= 1'b1;
      r_cr            <= w_c;
    end
`ifdef ALU_MUL_EN
    else if (w_mul_ack) begin
      r_out           <= w_prod[WIDTH-1:0];
      r_flags[FLAG_N] <= w_prod[WIDTH-1];
      r_flags[FLAG_Z] <= (w_prod[WIDTH-1:0] == '0);
      r_flags[FLAG_C] <= (w_prod[2*WIDTH-1:WIDTH] != '0);
      r_flags[FLAG_V] <= 1'b0;
      r_out_valid     <= 1'b1;
      r_cr            <= (w_prod[2*WIDTH-1:WIDTH] != '0);
    end
`endif
    else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign flags     = r_flags;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8 and WIDTH=16; MUL checks
// are built only when ALU_MUL_EN is defined.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, out;
  logic [3:0] op = '0, flags;
  logic [2:0] shamt = '0;

  logic        w_in_valid = 1'b0, w_in_ready, w_out_valid;
  logic [15:0] w_a = '0, w_b = '0, w_out;
  logic [3:0]  w_op = '0, w_flags;
  logic [3:0]  w_shamt = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .flags(flags)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .shamt(w_shamt), .out_valid(w_out_valid),
    .out_ready(1'b1), .out(w_out), .flags(w_flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one op for one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] sh);
    op = o; a = va; b = vb; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check("rst out", out, 8'h00);
    check("rst flags", flags, 4'h0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // ADD overflow into sign bit
    issue(4'd0, 8'h7F, 8'h01, 3'd0);
    check("add out", out, 8'h80);
    check("add flags", flags, 4'b1001);
    check("add valid", out_valid, 1'b1);
    tick();
    check("add valid drop", out_valid, 1'b0);

    // SUB then SBC back-to-back, borrow propagates
    op = 4'd1; a = 8'h00; b = 8'h01; shamt = '0; in_valid = 1'b1;
    tick();
    check("sub out", out, 8'hFF);
    check("sub flags", flags, 4'b1000);
    op = 4'd9; a = 8'h00; b = 8'h00;
    tick();
    in_valid = 1'b0;
    check("sbc out", out, 8'hFF);
    check("sbc flags", flags, 4'b1000);
    check("sbc valid", out_valid, 1'b1);

    // ADD carry out then ADC chain with no bubble
    op = 4'd0; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    tick();
    check("add carry out", out, 8'h00);
    check("add carry flags", flags, 4'b0110);
    op = 4'd8; a = 8'h00; b = 8'h00;
    tick();
    in_valid = 1'b0;
    check("adc out", out, 8'h01);
    check("adc flags", flags, 4'b0000);
    tick();

    // back-pressure hold, then replace on the draining edge
    out_ready = 1'b0;
    issue(4'd3, 8'hF0, 8'h3C, 3'd0);
    check("and out", out, 8'h30);
    check("and flags", flags, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold in_ready", in_ready, 1'b0);
      check("hold out", out, 8'h30);
      check("hold valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    op = 4'd5; a = 8'hFF; b = 8'h0F; in_valid = 1'b1;
    #1;
    check("drain in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("eor replace out", out, 8'hF0);
    check("eor replace valid", out_valid, 1'b1);
    tick();
    check("eor drained", out_valid, 1'b0);

    // shifts
    issue(4'd10, 8'h90, 8'h00, 3'd3);
    check("asr out", out, 8'hF2);
    check("asr flags", flags, 4'b1000);
    issue(4'd11, 8'h01, 8'h00, 3'd1);
    check("ror out", out, 8'h80);
    check("ror flags", flags, 4'b1010);
    issue(4'd6, 8'h81, 8'h00, 3'd1);
    check("lsl out", out, 8'h02);
    check("lsl flags", flags, 4'b0010);
    issue(4'd7, 8'hA5, 8'h00, 3'd0);
    check("lsr0 out", out, 8'hA5);
    check("lsr0 flags", flags, 4'b1000);
    issue(4'd7, 8'h81, 8'h00, 3'd1);
    check("lsr out", out, 8'h40);
    check("lsr flags", flags, 4'b0010);
    issue(4'd11, 8'h81, 8'h00, 3'd0);
    check("ror0 out", out, 8'h81);
    check("ror0 flags", flags, 4'b1000);

    // logic, NEG and default ops
    issue(4'd2, 8'h00, 8'h0F, 3'd0);
    check("neg out", out, 8'hF0);
    issue(4'd4, 8'h0A, 8'h50, 3'd0);
    check("orr out", out, 8'h5A);
    issue(4'd13, 8'h5A, 8'hFF, 3'd0);
    check("op13 out", out, 8'h5A);
    check("op13 flags", flags, 4'b0000);
    issue(4'd15, 8'h00, 8'hFF, 3'd0);
    check("op15 flags", flags, 4'b0100);

`ifdef ALU_MUL_EN
    begin
      int lat = 0;
      int low = 0;
      issue(4'd12, 8'h10, 8'h11, 3'd0);
      while (!out_valid && lat < 30) begin
        if (!in_ready) low++;
        tick();
        lat++;
      end
      check("mul latency", lat, 9);
      check("mul ready low", (low >= 8), 1'b1);
      check("mul out", out, 8'h10);
      check("mul flags", flags, 4'b0010);
      tick();
      issue(4'd12, 8'h10, 8'h11, 3'd0);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("mulrst valid", out_valid, 1'b0);
      check("mulrst out", out, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
        tick();
        check("mulrst no pulse", out_valid, 1'b0);
      end
      check("mulrst in_ready", in_ready, 1'b1);
    end
`else
    issue(4'd12, 8'h10, 8'h11, 3'd0);
    check("op12 default out", out, 8'h10);
    check("op12 default flags", flags, 4'b0000);
    check("op12 default ready", in_ready, 1'b1);
`endif

    // WIDTH=16 regression
    w_op = 4'd0; w_a = 16'hFFFF; w_b = 16'h0001; w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    check("w16 add out", w_out, 16'h0000);
    check("w16 add flags", w_flags, 4'b0110);
    check("w16 add valid", w_out_valid, 1'b1);
    w_op = 4'd14; w_a = 16'h1234; w_b = 16'h0000; w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    check("w16 op14 out", w_out, 16'h1234);
    check("w16 op14 flags", w_flags, 4'b0000);
    w_op = 4'd10; w_a = 16'h8000; w_shamt = 4'd15; w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    check("w16 asr out", w_out, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
